// File: rtl/pipeline_stall_controller.sv
// Stall/flush/bubble arbiter for the 5-stage MIPS pipeline with SRAM wait tracking and watchdog.
// Define PERF_COUNTERS_EN to build the saturating stall/flush performance counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_Detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_stall;

  assign mem_stall = mem_access && !sram_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // mem_access dropping mid-wait is ignored: the access is only released by sram_ready.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT_C) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Priority in RUN: memory stall, then taken branch (squashes ID, so hazard is moot), then hazard.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    mem_error     = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            freeze_all   = 1'b1;
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
          end else if (branch_taken) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
          end else if (hazard_Detected) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
          end
        end
        MEM_WAIT: begin
          freeze_all   = 1'b1;
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
        end
        ERROR: begin
          freeze_all   = 1'b1;
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          mem_error    = 1'b1;
        end
        default: begin
          freeze_pc = 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze_pc)   stall_cnt <= sat_inc(stall_cnt);
      if (flush_if_id) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: two instances (long and short watchdog / wide and narrow counters).
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_Detected = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_access = 1'b0;
  logic sram_ready = 1'b0;

  logic a_fpc, a_fifid, a_bub, a_flush, a_fall, a_err;
  logic b_fpc, b_fifid, b_bub, b_flush, b_fall, b_err;
  logic [15:0] a_stall, a_flushes;
  logic [3:0]  b_stall, b_flushes;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(64), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .hazard_Detected(hazard_Detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .sram_ready(sram_ready), .freeze_pc(a_fpc), .freeze_if_id(a_fifid),
    .bubble_id_exe(a_bub), .flush_if_id(a_flush), .freeze_all(a_fall), .mem_error(a_err),
    .stall_cycles(a_stall), .flush_events(a_flushes)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .hazard_Detected(hazard_Detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .sram_ready(sram_ready), .freeze_pc(b_fpc), .freeze_if_id(b_fifid),
    .bubble_id_exe(b_bub), .flush_if_id(b_flush), .freeze_all(b_fall), .mem_error(b_err),
    .stall_cycles(b_stall), .flush_events(b_flushes)
  );

  // Control vector order: {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all, mem_error}
  localparam logic [5:0] C0 = 6'b000000;
  localparam logic [5:0] CH = 6'b111000;
  localparam logic [5:0] CB = 6'b001100;
  localparam logic [5:0] CF = 6'b110010;
  localparam logic [5:0] CE = 6'b110011;

  typedef struct {
    string      name;
    logic [5:0] ctl_a;
    logic [5:0] ctl_b;
    int         stall_a;
    int         flush_a;
    int         stall_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic int ce(input int v);
`ifdef PERF_COUNTERS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic step(input string name, input logic r, input logic h, input logic b,
                      input logic m, input logic s, input logic [5:0] ca, input logic [5:0] cb,
                      input int sa, input int fa, input int sb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; hazard_Detected = h; branch_taken = b; mem_access = m; sram_ready = s;
    e.name = name; e.ctl_a = ca; e.ctl_b = cb;
    e.stall_a = ce(sa); e.flush_a = ce(fa); e.stall_b = ce(sb);
    exp_q.push_back(e);
  endtask

  task automatic check_int(input string name, input string what, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s %s: got %0d, expected %0d", name, what, act, req);
    end
  endtask

  task automatic check_vec(input string name, input string what, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s %s: got %b, expected %b", name, what, act, req);
    end
  endtask

  // Monitor: the block presents its controls every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_vec(e.name, "ctl_a", {a_fpc, a_fifid, a_bub, a_flush, a_fall, a_err}, e.ctl_a);
      check_vec(e.name, "ctl_b", {b_fpc, b_fifid, b_bub, b_flush, b_fall, b_err}, e.ctl_b);
      check_int(e.name, "stall_a", int'(a_stall), e.stall_a);
      check_int(e.name, "flush_a", int'(a_flushes), e.flush_a);
      check_int(e.name, "stall_b", int'(b_stall), e.stall_b);
    end
  end

  initial begin
    // Reset and release
    repeat (3) step("rst", 0, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    step("idle", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    // Load-use hazard
    step("haz1", 1, 1, 0, 0, 0, CH, CH, 0, 0, 0);
    step("haz2", 1, 1, 0, 0, 0, CH, CH, 1, 0, 1);
    step("haz_after", 1, 0, 0, 0, 0, C0, C0, 2, 0, 2);
    // Branch beats hazard
    step("br_hz", 1, 1, 1, 0, 0, CB, CB, 2, 0, 2);
    step("br_after", 1, 0, 0, 0, 0, C0, C0, 2, 1, 2);
    // SRAM wait of 5 cycles with branch pending; short-watchdog instance times out meanwhile
    for (int k = 0; k < 5; k++) step("sram_wait", 1, 0, 1, 1, 0, CF, CF, 2 + k, 1, 2 + k);
    step("sram_rdy", 1, 0, 1, 1, 1, CF, CE, 7, 1, 7);
    step("sram_run", 1, 0, 1, 1, 1, CB, CE, 8, 1, 8);
    step("sram_idle", 1, 0, 0, 0, 0, C0, CE, 8, 2, 9);
    step("rst2", 0, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    step("idle2", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    // Watchdog with sram_ready held low
    for (int k = 0; k < 5; k++) step("wd_wait", 1, 0, 0, 1, 0, CF, CF, k, 0, k);
    step("wd_err1", 1, 0, 0, 1, 0, CF, CE, 5, 0, 5);
    step("wd_err2", 1, 0, 0, 1, 0, CF, CE, 6, 0, 6);
    step("wd_rdy", 1, 0, 0, 1, 1, CF, CE, 7, 0, 7);
    step("wd_idle", 1, 0, 0, 0, 0, C0, CE, 8, 0, 8);
    step("rst3", 0, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    step("idle3", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    // Reset asserted mid-MEM_WAIT
    step("mw1", 1, 0, 0, 1, 0, CF, CF, 0, 0, 0);
    step("mw2", 1, 0, 0, 1, 0, CF, CF, 1, 0, 1);
    step("mw_rst", 0, 1, 1, 1, 0, C0, C0, 0, 0, 0);
    step("mw_rel", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    // Single-cycle access causes no freeze
    step("single", 1, 0, 0, 1, 1, C0, C0, 0, 0, 0);
    step("single_after", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    // mem_access dropped mid-wait: keep waiting for sram_ready
    step("pv1", 1, 0, 0, 1, 0, CF, CF, 0, 0, 0);
    step("pv2", 1, 1, 1, 0, 0, CF, CF, 1, 0, 1);
    step("pv3", 1, 0, 0, 0, 1, CF, CF, 2, 0, 2);
    step("pv4", 1, 0, 0, 0, 0, C0, C0, 3, 0, 3);
    // Saturation of the narrow counter
    step("rst4", 0, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    step("idle4", 1, 0, 0, 0, 0, C0, C0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step("sat", 1, 1, 0, 0, 0, CH, CH, k, 0, (k > 15) ? 15 : k);
    step("sat_idle", 1, 0, 0, 0, 0, C0, C0, 20, 0, 15);
    step("sat_hold", 1, 0, 0, 0, 0, C0, C0, 20, 0, 15);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
